// File: rtl/hazard_scoreboard_if.sv
// Issue-side and EX-side signals of the hazard scoreboard.
// The master drives the ID instruction and pipeline controls; the slave returns stall, selects and busy.
interface hazard_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int FW     = 2
);
  logic              issue_valid_i;
  logic [REG_AW-1:0] issue_rs_i;
  logic [REG_AW-1:0] issue_rt_i;
  logic              issue_rs_use_i;
  logic              issue_rt_use_i;
  logic [REG_AW-1:0] issue_rd_i;
  logic              issue_regwr_i;
  logic              issue_load_i;
  logic              flush_i;
  logic              freeze_i;
  logic              stall_o;
  logic [FW-1:0]     ex_fwd_rs_o;
  logic [FW-1:0]     ex_fwd_rt_o;
  logic              busy_o;

  modport master (
    output issue_valid_i, issue_rs_i, issue_rt_i, issue_rs_use_i, issue_rt_use_i,
    output issue_rd_i, issue_regwr_i, issue_load_i, flush_i, freeze_i,
    input  stall_o, ex_fwd_rs_o, ex_fwd_rt_o, busy_o
  );

  modport slave (
    input  issue_valid_i, issue_rs_i, issue_rt_i, issue_rs_use_i, issue_rt_use_i,
    input  issue_rd_i, issue_regwr_i, issue_load_i, flush_i, freeze_i,
    output stall_o, ex_fwd_rs_o, ex_fwd_rt_o, busy_o
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Scoreboard of in-flight destination registers between ID and EX: decides issue
// stalls combinationally and registers the EX operand bypass selects.
module hazard_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int ALU_LAT  = 2,
  parameter int LD_LAT   = 3,
  parameter bit ZERO_REG = 1'b1,
  localparam int FW      = $clog2(DEPTH + 1)
) (
  input logic              clk_i,
  input logic              rst_i,
  hazard_scoreboard_if.slave sb
);

  logic [DEPTH:1]             valid_q, valid_d;
  logic [DEPTH:1][REG_AW-1:0] rd_q, rd_d;
  logic [DEPTH:1]             load_q, load_d;
  logic [FW-1:0]              fwd_rs_q, fwd_rs_d;
  logic [FW-1:0]              fwd_rt_q, fwd_rt_d;

  logic [FW-1:0] rs_k_s, rt_k_s;
  logic          rs_haz_s, rt_haz_s;
  logic          stall_s, adv_s;

  function automatic logic src_match(input logic ent_valid, input logic use_bit,
                                     input logic [REG_AW-1:0] src, input logic [REG_AW-1:0] rd);
    return ent_valid && use_bit && (src == rd) && !(ZERO_REG && (rd == '0));
  endfunction

  // Youngest matching stage per source; walking old-to-young lets the youngest win.
  always_comb begin
    rs_k_s   = '0;
    rt_k_s   = '0;
    rs_haz_s = 1'b0;
    rt_haz_s = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      rs_haz_s = src_match(valid_q[k], sb.issue_rs_use_i, sb.issue_rs_i, rd_q[k]) ?
                 ((k + 1) < (load_q[k] ? LD_LAT : ALU_LAT)) : rs_haz_s;
      rs_k_s   = src_match(valid_q[k], sb.issue_rs_use_i, sb.issue_rs_i, rd_q[k]) ?
                 FW'(k) : rs_k_s;
      rt_haz_s = src_match(valid_q[k], sb.issue_rt_use_i, sb.issue_rt_i, rd_q[k]) ?
                 ((k + 1) < (load_q[k] ? LD_LAT : ALU_LAT)) : rt_haz_s;
      rt_k_s   = src_match(valid_q[k], sb.issue_rt_use_i, sb.issue_rt_i, rd_q[k]) ?
                 FW'(k) : rt_k_s;
    end
    stall_s = sb.issue_valid_i && (rs_haz_s || rt_haz_s);
    adv_s   = sb.issue_valid_i && !stall_s && !sb.flush_i;
  end

  // Pipeline shift and select capture; a freeze holds everything in place.
  always_comb begin
    valid_d  = valid_q;
    rd_d     = rd_q;
    load_d   = load_q;
    fwd_rs_d = fwd_rs_q;
    fwd_rt_d = fwd_rt_q;
    if (!sb.freeze_i) begin
      for (int k = DEPTH; k >= 2; k--) begin
        valid_d[k] = valid_q[k-1];
        rd_d[k]    = rd_q[k-1];
        load_d[k]  = load_q[k-1];
      end
      // Non-writing instructions enter as bubbles so they never match.
      valid_d[1] = adv_s && sb.issue_regwr_i;
      rd_d[1]    = adv_s ? sb.issue_rd_i : '0;
      load_d[1]  = adv_s && sb.issue_load_i;
      // A producer in the last stage is covered by register-file write-through.
      fwd_rs_d   = (adv_s && (rs_k_s != '0) && (int'(rs_k_s) < DEPTH)) ? rs_k_s + FW'(1) : '0;
      fwd_rt_d   = (adv_s && (rt_k_s != '0) && (int'(rt_k_s) < DEPTH)) ? rt_k_s + FW'(1) : '0;
    end else begin
      valid_d  = valid_q;
      fwd_rs_d = fwd_rs_q;
      fwd_rt_d = fwd_rt_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= '0;
      rd_q     <= '0;
      load_q   <= '0;
      fwd_rs_q <= '0;
      fwd_rt_q <= '0;
    end else begin
      valid_q  <= valid_d;
      rd_q     <= rd_d;
      load_q   <= load_d;
      fwd_rs_q <= fwd_rs_d;
      fwd_rt_q <= fwd_rt_d;
    end
  end

  assign sb.stall_o     = stall_s;
  assign sb.ex_fwd_rs_o = fwd_rs_q;
  assign sb.ex_fwd_rt_o = fwd_rt_q;
  assign sb.busy_o      = |valid_q;

endmodule
